// File: rtl/decoder_2_4_pkg.sv
// Shared widths for the 1:2 / 2:4 decoders, the output register stage
// and the 8-way cascade built from them.
package decoder_2_4_pkg;

  localparam int SEL2_W = 1;
  localparam int SEL4_W = 2;
  localparam int OUT2_W = 2;
  localparam int OUT4_W = 4;

  localparam int SEL8_W = SEL2_W + SEL4_W;
  localparam int OUT8_W = OUT2_W * OUT4_W;

  localparam int REG_W  = OUT2_W + OUT4_W;

endpackage : decoder_2_4_pkg

// File: rtl/decoder_2_4_if.sv
// Bundle of enable, selects and decoded outputs shared by the decoder top
// and whoever drives it.
interface decoder_2_4_if;
  import decoder_2_4_pkg::*;

  logic              en;
  logic [SEL2_W-1:0] in2;
  logic [SEL4_W-1:0] in4;
  logic [OUT2_W-1:0] out2;
  logic [OUT4_W-1:0] out4;
  logic [OUT2_W-1:0] out2_q;
  logic [OUT4_W-1:0] out4_q;

  modport master (
    output en,
    output in2,
    output in4,
    input  out2,
    input  out4,
    input  out2_q,
    input  out4_q
  );

  modport slave (
    input  en,
    input  in2,
    input  in4,
    output out2,
    output out4,
    output out2_q,
    output out4_q
  );

endinterface : decoder_2_4_if

// File: rtl/decode_reg.sv
// Width-parameterised output register, loads every rising edge and clears
// asynchronously on reset.
module decode_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
  end

  // Reset wins over a coincident clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : decode_reg

// File: rtl/decoder_2.sv
// Combinational 1:2 one-hot decoder; all outputs low when en is low.
module decoder_2
  import decoder_2_4_pkg::*;
(
  input  logic              en,
  input  logic [SEL2_W-1:0] in,
  output logic [OUT2_W-1:0] out
);

  generate
    for (genvar gi = 0; gi < OUT2_W; gi++) begin : g_bit
      assign out[gi] = en & (in == SEL2_W'(gi));
    end
  endgenerate

endmodule : decoder_2

// File: rtl/decoder_4.sv
// Combinational 2:4 one-hot decoder; all outputs low when en is low.
module decoder_4
  import decoder_2_4_pkg::*;
(
  input  logic              en,
  input  logic [SEL4_W-1:0] in,
  output logic [OUT4_W-1:0] out
);

  generate
    for (genvar gi = 0; gi < OUT4_W; gi++) begin : g_bit
      assign out[gi] = en & (in == SEL4_W'(gi));
    end
  endgenerate

endmodule : decoder_4

// File: rtl/decoder_8.sv
// 3:8 decoder built by cascading: the 1:2 stage on select bit 2 enables
// either the low or the high 2:4 stage.
module decoder_8
  import decoder_2_4_pkg::*;
(
  input  logic              en,
  input  logic [SEL8_W-1:0] in,
  output logic [OUT8_W-1:0] out
);

  logic [OUT2_W-1:0] half_en;

  decoder_2 u_half (
    .en  (en),
    .in  (in[SEL8_W-1]),
    .out (half_en)
  );

  generate
    for (genvar gi = 0; gi < OUT2_W; gi++) begin : g_quarter
      decoder_4 u_quarter (
        .en  (half_en[gi]),
        .in  (in[SEL4_W-1:0]),
        .out (out[gi*OUT4_W +: OUT4_W])
      );
    end
  endgenerate

endmodule : decoder_8

// File: rtl/decoder_2_4.sv
// Top: one 1:2 and one 2:4 decoder sharing an enable, with an optional
// single register stage behind both combinational outputs.
module decoder_2_4
  import decoder_2_4_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  decoder_2_4_if.slave  bus
);

  logic [OUT2_W-1:0] out2;
  logic [OUT4_W-1:0] out4;

  decoder_2 u_dec2 (
    .en  (bus.en),
    .in  (bus.in2),
    .out (out2)
  );

  decoder_4 u_dec4 (
    .en  (bus.en),
    .in  (bus.in4),
    .out (out4)
  );

  assign bus.out2 = out2;
  assign bus.out4 = out4;

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [REG_W-1:0] reg_q;

      decode_reg #(.W(REG_W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .d     ({out2, out4}),
        .q     (reg_q)
      );

      assign bus.out2_q = reg_q[OUT4_W +: OUT2_W];
      assign bus.out4_q = reg_q[OUT4_W-1:0];
    end else begin : g_comb
      // Unregistered build: clock and reset have no load here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;

      assign bus.out2_q = out2;
      assign bus.out4_q = out4;
    end
  endgenerate

endmodule : decoder_2_4

// File: tb/tb_decoder_2_4.sv
// Directed and random checks of decoder_2_4 (registered and pass-through
// builds) and of the 3:8 cascade.
module tb_decoder_2_4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  decoder_2_4_if bus_r ();
  decoder_2_4_if bus_c ();

  logic       en8  = 1'b0;
  logic [2:0] in8  = 3'd0;
  logic [7:0] out8;

  decoder_2_4 #(.OUT_REG(1)) dut_r (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r.slave)
  );

  decoder_2_4 #(.OUT_REG(0)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c.slave)
  );

  decoder_8 dut_8 (
    .en  (en8),
    .in  (in8),
    .out (out8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic in2, input logic [1:0] in4);
    bus_r.en = en; bus_r.in2 = in2; bus_r.in4 = in4;
    bus_c.en = en; bus_c.in2 = in2; bus_c.in4 = in4;
  endtask

  logic [3:0] exp4_prev;
  logic [1:0] exp2_prev;
  logic       r_en;
  logic       r_in2;
  logic [1:0] r_in4;

  initial begin
    drive(1'b1, 1'b1, 2'd2);

    // Reset asserted: registers cleared, combinational path still live.
    #12;
    check("rst_out2_q", {6'd0, bus_r.out2_q}, 8'b0000_0000);
    check("rst_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0000);
    check("rst_out4_comb", {4'd0, bus_r.out4}, 8'b0000_0100);
    check("rst_out2_comb", {6'd0, bus_r.out2}, 8'b0000_0010);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0000);

    // Disabled: everything zero.
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0);
    #1;
    check("dis_out2", {6'd0, bus_r.out2}, 8'b0000_0000);
    check("dis_out4", {4'd0, bus_r.out4}, 8'b0000_0000);
    drive(1'b0, 1'b1, 2'd3);
    #1;
    check("dis_out2_sel1", {6'd0, bus_r.out2}, 8'b0000_0000);
    check("dis_out4_sel3", {4'd0, bus_r.out4}, 8'b0000_0000);

    // Enabled sweeps.
    drive(1'b1, 1'b0, 2'd0); #1; check("out4_sel0", {4'd0, bus_r.out4}, 8'b0000_0001);
    drive(1'b1, 1'b0, 2'd1); #1; check("out4_sel1", {4'd0, bus_r.out4}, 8'b0000_0010);
    drive(1'b1, 1'b0, 2'd2); #1; check("out4_sel2", {4'd0, bus_r.out4}, 8'b0000_0100);
    drive(1'b1, 1'b0, 2'd3); #1; check("out4_sel3", {4'd0, bus_r.out4}, 8'b0000_1000);
    drive(1'b1, 1'b0, 2'd0); #1; check("out2_sel0", {6'd0, bus_r.out2}, 8'b0000_0001);
    drive(1'b1, 1'b1, 2'd0); #1; check("out2_sel1", {6'd0, bus_r.out2}, 8'b0000_0010);

    // One-cycle latency: load in4=0, then switch to in4=2.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0);
    @(posedge clk); #1;
    check("lat_prev_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0001);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2);
    #1;
    check("lat_out4_now", {4'd0, bus_r.out4}, 8'b0000_0100);
    check("lat_out4_q_not_yet", {4'd0, bus_r.out4_q}, 8'b0000_0001);
    @(posedge clk); #1;
    check("lat_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0100);
    check("lat_out2_q", {6'd0, bus_r.out2_q}, 8'b0000_0010);

    // Asynchronous reset between edges while out4_q = 1000.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd3);
    @(posedge clk); #1;
    check("pre_async_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_1000);
    #2;
    reset = 1'b1;
    #1;
    check("async_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0000);
    check("async_out2_q", {6'd0, bus_r.out2_q}, 8'b0000_0000);
    check("async_out4_comb", {4'd0, bus_r.out4}, 8'b0000_1000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("resume_hold_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_0000);
    @(posedge clk); #1;
    check("resume_out4_q", {4'd0, bus_r.out4_q}, 8'b0000_1000);

    // 8-way cascade.
    en8 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] one;
      one = 8'd1;
      in8 = 3'(s);
      #1;
      check($sformatf("cascade_sel%0d", s), out8, one << s);
    end
    en8 = 1'b0;
    for (int s = 0; s < 8; s++) begin
      in8 = 3'(s);
      #1;
      check($sformatf("cascade_dis%0d", s), out8, 8'b0000_0000);
    end

    // Random traffic: one-hot count tracks en, registers trail by one cycle.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      r_en  = 1'($urandom_range(0, 1));
      r_in2 = 1'($urandom_range(0, 1));
      r_in4 = 2'($urandom_range(0, 3));
      drive(r_en, r_in2, r_in4);
      #1;
      exp4_prev = r_en ? (4'b0001 << r_in4) : 4'b0000;
      exp2_prev = r_en ? (2'b01 << r_in2) : 2'b00;
      check("rnd_onehot4", 8'($countones(bus_r.out4)), {7'd0, r_en});
      check("rnd_onehot2", 8'($countones(bus_r.out2)), {7'd0, r_en});
      check("rnd_out4", {4'd0, bus_r.out4}, {4'd0, exp4_prev});
      check("rnd_passthru4", {4'd0, bus_c.out4_q}, {4'd0, exp4_prev});
      @(posedge clk); #1;
      check("rnd_out4_q", {4'd0, bus_r.out4_q}, {4'd0, exp4_prev});
      check("rnd_out2_q", {6'd0, bus_r.out2_q}, {6'd0, exp2_prev});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_2_4
